// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the instruction-fetch stage
package fetch_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] INSTR_BYTES = 64'd4;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner issuing one outstanding imem read and feeding the IF/ID entry
// A redirect flushes the entry; a fetch still in flight at that point is drained and discarded.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic [PC_W-1:0]    if_nextseqpc
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] inflight_pc;
    logic            handshake;
    logic            rsp_load;

    assign handshake     = imem_req_valid && imem_req_ready;
    assign rsp_load      = (state == WAIT) && imem_rsp_valid;
    assign imem_req_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            REQ: begin
                if (handshake) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A response coincident with a redirect is simply dropped; nothing left to drain.
                if (imem_rsp_valid) begin
                    state_next = REQ;
                end else if (redirect_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = REQ;
        endcase
    end

    // Only request when the entry is empty or being consumed, so the response always has a home.
    always_comb begin
        imem_req_valid = 1'b0;
        if (state == REQ) begin
            imem_req_valid = !reset && !redirect_valid && (!if_valid || !stall);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (rsp_load) begin
            pc <= inflight_pc + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_pc <= '0;
        end else if (handshake) begin
            inflight_pc <= pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_valid     <= 1'b0;
            if_instr     <= '0;
            if_pc        <= '0;
            if_nextseqpc <= '0;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
        end else if (rsp_load) begin
            if_valid     <= 1'b1;
            if_instr     <= imem_rsp_data;
            if_pc        <= inflight_pc;
            if_nextseqpc <= inflight_pc + INSTR_BYTES;
        end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency memory model
module tb_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic [63:0] if_nextseqpc;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_nextseqpc   (if_nextseqpc)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] req_addr_log[$];
    int          req_cyc_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_total = 0;
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [63:0] mem_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'hD503201F + a[31:0] - 32'h0000_1000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory drives its response just after the rising edge; everything is sampled at the falling edge.
    initial begin : mem_and_monitor
        logic        prev_hold;
        logic        prev_pend;
        logic [63:0] prev_pc;
        logic [31:0] prev_instr;
        logic [63:0] prev_addr;
        exp_t        e;
        prev_hold = 1'b0;
        prev_pend = 1'b0;
        prev_pc = '0;
        prev_instr = '0;
        prev_addr = '0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) mem_cnt = 0;
            rsp_valid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data = mem_word(mem_addr);
                end
            end
            @(negedge clk);
            cyc++;
            if (reset) begin
                sb.delete();
                mem_cnt = 0;
                prev_hold = 1'b0;
                prev_pend = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", {63'd0, if_valid}, 64'd1);
                    check("hold_pc", if_pc, prev_pc);
                    check("hold_instr", {32'd0, if_instr}, {32'd0, prev_instr});
                end
                if (prev_pend && !redirect_valid) begin
                    check("req_stable_valid", {63'd0, req_valid}, 64'd1);
                    check("req_stable_addr", req_addr, prev_addr);
                end
                if (if_valid && !stall) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected", if_pc, 64'hX);
                    end else begin
                        e = sb.pop_front();
                        check("sb_pc", if_pc, e.pc);
                        check("sb_instr", {32'd0, if_instr}, {32'd0, e.instr});
                        check("sb_nextseqpc", if_nextseqpc, e.pc + 64'd4);
                    end
                end
                if (redirect_valid) sb.delete();
                if (req_valid && req_ready) begin
                    check("one_outstanding", 64'(mem_cnt), 64'd0);
                    e.pc = req_addr;
                    e.instr = mem_word(req_addr);
                    sb.push_back(e);
                    req_addr_log.push_back(req_addr);
                    req_cyc_log.push_back(cyc);
                    hs_total++;
                    mem_cnt = mem_lat;
                    mem_addr = req_addr;
                end
                prev_hold = if_valid && stall && !redirect_valid;
                prev_pc = if_pc;
                prev_instr = if_instr;
                prev_pend = req_valid && !req_ready;
                prev_addr = req_addr;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_hs(input string tag);
        int n;
        n = 0;
        next();
        #1;
        while (!(req_valid && req_ready) && n < 50) begin
            next();
            #1;
            n++;
        end
        check(tag, {63'd0, n < 50}, 64'd1);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        next();
        #1;
        while (!req_valid && n < 50) begin
            next();
            #1;
            n++;
        end
        check(tag, {63'd0, n < 50}, 64'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          hs0;
        logic [63:0] pc0;
        logic [63:0] addr0;
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        req_ready = 1'b1;
        mem_lat = 1;

        repeat (3) next();
        #1;
        check("rst_req_valid", {63'd0, req_valid}, 64'd0);
        check("rst_if_valid", {63'd0, if_valid}, 64'd0);
        check("rst_if_instr", {32'd0, if_instr}, 64'd0);
        check("rst_if_pc", if_pc, 64'd0);
        check("rst_if_nextseqpc", if_nextseqpc, 64'd0);

        // Sequential fetch with a one-cycle memory
        next();
        reset = 1'b0;
        #1;
        check("first_req_valid", {63'd0, req_valid}, 64'd1);
        check("first_req_addr", req_addr, RST_PC);
        next();
        #1;
        check("wait_no_req", {63'd0, req_valid}, 64'd0);
        check("wait_if_valid", {63'd0, if_valid}, 64'd0);
        next();
        #1;
        check("lat_if_valid", {63'd0, if_valid}, 64'd1);
        check("lat_if_pc", if_pc, 64'h1000);
        check("lat_if_instr", {32'd0, if_instr}, 64'hD503201F);
        check("lat_if_nextseqpc", if_nextseqpc, 64'h1004);
        check("lat_next_req_valid", {63'd0, req_valid}, 64'd1);
        check("lat_next_req_addr", req_addr, 64'h1004);
        repeat (3) next();
        check("req_log_len", {63'd0, req_addr_log.size() >= 3}, 64'd1);
        if (req_addr_log.size() >= 3) begin
            check("req_addr0", req_addr_log[0], 64'h1000);
            check("req_addr1", req_addr_log[1], 64'h1004);
            check("req_addr2", req_addr_log[2], 64'h1008);
            check("req_gap01", 64'(req_cyc_log[1] - req_cyc_log[0]), 64'd2);
            check("req_gap12", 64'(req_cyc_log[2] - req_cyc_log[1]), 64'd2);
        end

        // Stall for five cycles with a live entry
        begin
            int n;
            n = 0;
            next();
            #1;
            while (!if_valid && n < 50) begin
                next();
                #1;
                n++;
            end
            check("stall_find_entry", {63'd0, n < 50}, 64'd1);
        end
        stall = 1'b1;
        #1;
        check("stall_no_req", {63'd0, req_valid}, 64'd0);
        hs0 = hs_total;
        pc0 = if_pc;
        repeat (4) next();
        next();
        stall = 1'b0;
        #1;
        check("stall_hs_during", 64'(hs_total - hs0), 64'd0);
        check("stall_pc_held", if_pc, pc0);
        check("stall_release_req", {63'd0, req_valid}, 64'd1);
        next();
        check("stall_hs_after", 64'(hs_total - hs0), 64'd1);

        // Redirect in WAIT, stale response three cycles after acceptance
        mem_lat = 3;
        wait_hs("redir_wait_hs");
        next();
        redirect_valid = 1'b1;
        redirect_pc = 64'h2000;
        #1;
        next();
        redirect_valid = 1'b0;
        #1;
        check("redir_flush", {63'd0, if_valid}, 64'd0);
        check("redir_drain_noreq", {63'd0, req_valid}, 64'd0);
        next();
        #1;
        check("redir_drain_noreq2", {63'd0, req_valid}, 64'd0);
        next();
        #1;
        check("redir_req_valid", {63'd0, req_valid}, 64'd1);
        check("redir_req_addr", req_addr, 64'h2000);
        check("redir_no_stale", {63'd0, if_valid}, 64'd0);

        // Redirect coincident with the response
        mem_lat = 2;
        wait_hs("coinc_hs");
        next();
        next();
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        #1;
        check("coinc_rsp_present", {63'd0, rsp_valid}, 64'd1);
        check("coinc_no_req", {63'd0, req_valid}, 64'd0);
        next();
        redirect_valid = 1'b0;
        #1;
        check("coinc_req_valid", {63'd0, req_valid}, 64'd1);
        check("coinc_req_addr", req_addr, 64'h3000);
        check("coinc_if_valid", {63'd0, if_valid}, 64'd0);

        // Backpressure on the request channel
        mem_lat = 1;
        req_ready = 1'b0;
        wait_req("bp_find_req");
        addr0 = req_addr;
        hs0 = hs_total;
        repeat (3) begin
            next();
            #1;
            check("bp_valid", {63'd0, req_valid}, 64'd1);
            check("bp_addr", req_addr, addr0);
        end
        next();
        req_ready = 1'b1;
        #1;
        check("bp_rise_valid", {63'd0, req_valid}, 64'd1);
        check("bp_hs_before", 64'(hs_total - hs0), 64'd0);
        next();
        check("bp_hs_after", 64'(hs_total - hs0), 64'd1);

        // Redirect in REQ to the top of the address space
        wait_req("wrap_find_req");
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        check("wrap_redir_noreq", {63'd0, req_valid}, 64'd0);
        next();
        redirect_valid = 1'b0;
        #1;
        check("wrap_req_valid", {63'd0, req_valid}, 64'd1);
        check("wrap_req_addr", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        next();
        next();
        #1;
        check("wrap_if_valid", {63'd0, if_valid}, 64'd1);
        check("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_nextseqpc", if_nextseqpc, 64'd0);
        check("wrap_next_addr", req_addr, 64'd0);

        // Reset while a fetch is in flight
        mem_lat = 3;
        wait_hs("rstw_hs");
        next();
        reset = 1'b1;
        #1;
        check("rstw_req_valid", {63'd0, req_valid}, 64'd0);
        check("rstw_if_valid", {63'd0, if_valid}, 64'd0);
        check("rstw_if_instr", {32'd0, if_instr}, 64'd0);
        check("rstw_if_pc", if_pc, 64'd0);
        check("rstw_if_nextseqpc", if_nextseqpc, 64'd0);
        next();
        reset = 1'b0;
        mem_lat = 1;
        #1;
        check("rstw_req_valid_after", {63'd0, req_valid}, 64'd1);
        check("rstw_req_addr_after", req_addr, RST_PC);
        repeat (6) next();

        // Quiesce and confirm every accepted fetch was delivered exactly once
        req_ready = 1'b0;
        repeat (8) next();
        #1;
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_if_valid", {63'd0, if_valid}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the five-stage ARM64 pipeline: owns the PC, issues one outstanding read at a time to instruction memory over a valid/ready request and valid-only response channel, and presents each fetched word with its PC and next-sequential PC to the IF/ID pipeline register. It honours downstream stall (IF/ID write disable) and redirects from the branch-resolution stage, discarding any in-flight fetch made stale by a redirect.

## Interface
- RESET_PC, 64'h0, PC loaded on reset.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  downstream not accepting; the output entry must hold.
- redirect_valid  input  1  load new PC, flush fetch.
- redirect_pc  input  64  redirect target.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  64  read address, equal to the current PC.
- imem_rsp_valid  input  1  read data valid, one cycle wide, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- if_valid  output  1  output entry holds a live instruction.
- if_instr  output  32  fetched instruction.
- if_pc  output  64  address of if_instr.
- if_nextseqpc  output  64  if_pc + 4.

## Operation
- State machine: REQ, WAIT, DRAIN. Registers: pc, a single output entry (if_valid/if_instr/if_pc/if_nextseqpc), state.
- Consumed this cycle: if_valid && !stall.
- REQ: imem_req_valid = !redirect_valid && (!if_valid || !stall). imem_req_addr = pc. On handshake (valid && ready): go to WAIT, latch pc as the in-flight address.
- WAIT: on imem_rsp_valid: load the entry with instr=data, pc=in-flight address, nextseqpc=in-flight address+4, and if_valid=1. Set pc to in-flight address+4, then go to REQ.
- If the entry is consumed with no new load, clear if_valid. The entry fields hold their values while stalled.
- Redirect (any state): pc <= redirect_pc and if_valid <= 0 (flush). The next state depends on the current state:
  - REQ: stay in REQ. No request is issued that cycle.
  - WAIT without rsp: go to DRAIN.
  - WAIT with a simultaneous rsp: drop the rsp and go to REQ.
  - DRAIN: stay in DRAIN.
- DRAIN: imem_req_valid = 0. On imem_rsp_valid: discard the data and go to REQ.
- Arithmetic: +4 is a 64-bit add, wrapping modulo 2^64. No alignment check; redirect_pc is used as-is.
- Only one request outstanding. The request gate guarantees the entry is empty or freed when the response returns, so no response is ever lost.

## Timing
- Reset (async assert) sets the following. Release is sampled at the next rising edge.
  - pc = RESET_PC, state = REQ.
  - if_valid = 0; if_instr, if_pc and if_nextseqpc = 0.
  - imem_req_valid = 0 while reset is high.
- Minimum latency, with ready=1 and a 1-cycle memory:
  - request at cycle N, rsp at N+1, if_valid=1 at N+2;
  - next request at N+2.
  - Peak throughput is 1 instruction per 2 cycles.
- imem_req_valid and imem_req_addr are combinational from registered state. Once valid is raised, address and valid must stay stable until ready, unless a redirect or reset intervenes.
- Redirect takes effect at the next edge. The first request to redirect_pc is issued:
  - 1 cycle later if the redirect arrived in REQ;
  - the cycle after the drained rsp if it arrived in WAIT/DRAIN.
- Reset mid-WAIT/DRAIN: the state returns to REQ. A late rsp arriving after reset release in REQ is ignored; the memory must be reset with the core.

## Structure
- Package fetch_pkg holds:
  - the state enum (REQ, WAIT, DRAIN);
  - INSTR_BYTES = 4;
  - PC_W = 64, INSTR_W = 32.
- No sub-module: the state machine, PC and the single output entry sit in one module of roughly 150–200 lines.

## Test plan
- Reset, RESET_PC=64'h1000, ready=1, 1-cycle memory returning 32'hD503201F -> requests at 1000, 1004, 1008 every 2 cycles. The first if_pc=1000, if_nextseqpc=1004 with if_valid=1.
- stall=1 for 5 cycles while if_valid=1 -> the entry holds. At most one further request is issued, and only after stall falls. No instruction is duplicated or lost.
- Redirect to 64'h2000 while in WAIT, rsp for 1008 arriving 3 cycles later -> the 1008 data never appears on if_*. The next request address is 2000 and if_valid drops the cycle after the redirect.
- Redirect coincident with rsp in WAIT -> rsp dropped, no DRAIN, request to the new PC on the following cycle.
- imem_req_ready=0 for 4 cycles -> valid=1 and addr stable throughout. The handshake occurs on the cycle ready rises.
- Fetch at pc=64'hFFFF_FFFF_FFFF_FFFC -> if_nextseqpc=0, next request address 0. Also assert reset during WAIT -> all outputs zero and pc=RESET_PC.
